// File: rtl/tli4970_reader.sv
// TLI4970 current-sensor reader.
// Triggers a 16-bit read-only SPI frame (mode 0, MSB first) every SAMPLE_PERIOD
// clocks. Each frame is checked for even parity and then decoded into either
// a signed current sample with its overcurrent flag, or a status word.
module tli4970_reader #(
    parameter int CLK_DIV       = 16,
    parameter int SAMPLE_PERIOD = 64000,
    parameter int CS_SETUP      = 16,
    parameter int CS_HOLD       = 16
) (
    input  logic               CLK,
    input  logic               reset_n,
    input  logic               enable,
    output logic               CS,
    output logic               CS_CLK,
    input  logic               CS_MISO,
    output logic signed [12:0] current,
    output logic               current_valid,
    output logic               ocd,
    output logic [15:0]        status,
    output logic               status_valid,
    output logic               parity_err,
    output logic [7:0]         err_count,
    output logic               busy
);

    // Counter widths sized from the parameters.
    localparam int PW     = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int TMAX_A = ((2 * CLK_DIV) > CS_SETUP) ? (2 * CLK_DIV) : CS_SETUP;
    localparam int TMAX   = (TMAX_A > CS_HOLD) ? TMAX_A : CS_HOLD;
    localparam int TW     = $clog2(TMAX + 1);

    localparam logic [PW-1:0] CNT_LAST   = PW'(SAMPLE_PERIOD - 1);
    localparam logic [TW-1:0] SETUP_LAST = TW'(CS_SETUP - 1);
    localparam logic [TW-1:0] HOLD_LAST  = TW'(CS_HOLD - 1);
    localparam logic [TW-1:0] HALF_LAST  = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] BIT_LAST   = TW'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_SHIFT  = 3'd2,
        S_HOLD   = 3'd3,
        S_DECODE = 3'd4
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_cnt;
    logic [TW-1:0]   r_tmr;
    logic [3:0]      r_bit;
    logic [15:0]     r_frame;
    logic            r_miso_meta;
    logic            r_miso_sync;
    logic            w_trig;

    // Odd number of ones means the frame failed its even-parity check.
    function automatic logic f_parity_odd(input logic [15:0] d);
        return ^d;
    endfunction

    // Removing the 4096 offset from a 13-bit field is the same as flipping bit 12.
    function automatic logic signed [12:0] f_remove_offset(input logic [12:0] d);
        return {~d[12], d[11:0]};
    endfunction

    // A slot only fires when the reader is idle and enabled; otherwise it is skipped.
    assign w_trig = (r_cnt == CNT_LAST) && enable && (r_state == S_IDLE);

    // Two-flop synchronizer for the sensor data line (asynchronous to CLK).
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_miso_meta <= 1'b0;
            r_miso_sync <= 1'b0;
        end else begin
            r_miso_meta <= CS_MISO;
            r_miso_sync <= r_miso_meta;
        end
    end

    // Free-running sample period counter, wraps at SAMPLE_PERIOD-1.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + PW'(1);
        end
    end

    // Frame sequencer: CS/SCK generation, bit capture and decode into registered outputs.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_tmr         <= '0;
            r_bit         <= 4'd0;
            r_frame       <= 16'h0000;
            CS            <= 1'b1;
            CS_CLK        <= 1'b0;
            busy          <= 1'b0;
            current       <= 13'sd0;
            ocd           <= 1'b0;
            status        <= 16'h0000;
            err_count     <= 8'd0;
            current_valid <= 1'b0;
            status_valid  <= 1'b0;
            parity_err    <= 1'b0;
        end else begin
            current_valid <= 1'b0;
            status_valid  <= 1'b0;
            parity_err    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    CS     <= 1'b1;
                    CS_CLK <= 1'b0;
                    if (w_trig) begin
                        r_state <= S_SETUP;
                        r_tmr   <= '0;
                        r_frame <= 16'h0000;
                        CS      <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (r_tmr == SETUP_LAST) begin
                        r_state <= S_SHIFT;
                        r_tmr   <= '0;
                        r_bit   <= 4'd0;
                    end else begin
                        r_tmr <= r_tmr + TW'(1);
                    end
                end
                S_SHIFT: begin
                    // Low half first, then high half; data is taken at the end of the high half.
                    if (r_tmr == HALF_LAST) begin
                        CS_CLK <= 1'b1;
                    end
                    if (r_tmr == BIT_LAST) begin
                        CS_CLK  <= 1'b0;
                        r_frame <= {r_frame[14:0], r_miso_sync};
                        r_tmr   <= '0;
                        if (r_bit == 4'd15) begin
                            r_state <= S_HOLD;
                        end else begin
                            r_bit <= r_bit + 4'd1;
                        end
                    end else begin
                        r_tmr <= r_tmr + TW'(1);
                    end
                end
                S_HOLD: begin
                    if (r_tmr == HOLD_LAST) begin
                        r_state <= S_DECODE;
                        r_tmr   <= '0;
                        CS      <= 1'b1;
                    end else begin
                        r_tmr <= r_tmr + TW'(1);
                    end
                end
                S_DECODE: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    if (f_parity_odd(r_frame)) begin
                        parity_err <= 1'b1;
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                    end else if (!r_frame[15]) begin
                        current       <= f_remove_offset(r_frame[12:0]);
                        ocd           <= r_frame[13];
                        current_valid <= 1'b1;
                    end else begin
                        status       <= r_frame;
                        status_valid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    CS      <= 1'b1;
                    CS_CLK  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tli4970_reader.sv
// Scoreboard bench for tli4970_reader: directed frames with hand-computed results,
// a sensor model driving MISO, and a monitor checking pulses, SCK shape and latency.
module tb_tli4970_reader;

    localparam int DIV = 4;
    localparam int SP  = 160;
    localparam int SU  = 4;
    localparam int HO  = 4;
    localparam int LAT = 1 + SU + 32 * DIV + HO;  // CS fall cycle to result pulse
    localparam int TMO = 3 * SP;

    logic               CLK = 1'b0;
    logic               reset_n = 1'b0;
    logic               enable = 1'b0;
    logic               CS;
    logic               CS_CLK;
    logic               CS_MISO = 1'b0;
    logic signed [12:0] current;
    logic               current_valid;
    logic               ocd;
    logic [15:0]        status;
    logic               status_valid;
    logic               parity_err;
    logic [7:0]         err_count;
    logic               busy;

    tli4970_reader #(
        .CLK_DIV(DIV), .SAMPLE_PERIOD(SP), .CS_SETUP(SU), .CS_HOLD(HO)
    ) dut (
        .CLK(CLK), .reset_n(reset_n), .enable(enable), .CS(CS), .CS_CLK(CS_CLK),
        .CS_MISO(CS_MISO), .current(current), .current_valid(current_valid), .ocd(ocd),
        .status(status), .status_valid(status_valid), .parity_err(parity_err),
        .err_count(err_count), .busy(busy)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          kind;   // 0 data, 1 status, 2 parity error
        int          cur;
        int          ocd;
        int          st;
        int          errc;
    } exp_t;

    typedef struct {
        logic [15:0] f;
        int          kind;
        int          cur;
        int          ocd;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[7];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          m_cur = 0, m_ocd = 0, m_st = 0, m_err = 0;
    logic [15:0] next_frame = 16'h0000;
    logic [15:0] sh = 16'h0000;
    int          sck_edges = 0, hi_len = 0, bad_idle = 0, cs_fall_cyc = 0, cs_falls = 0;
    int          in_frame = 0, prev_cs = 1, prev_sck = 0, npulse = 0, kind_act = 0, cur_act = 0;
    exp_t        e;

    // Cycle index matching the DUT period counter since reset release.
    always @(posedge CLK or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // Sensor model: first bit on CS fall, next bit after each SCK falling edge.
    always @(negedge CS) begin
        sh = next_frame;
        CS_MISO = sh[15];
    end
    always @(negedge CS_CLK) begin
        if (CS === 1'b0) begin
            sh = {sh[14:0], 1'b0};
            CS_MISO = sh[15];
        end
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input int kind, input logic [15:0] f, input int cur, input int ocd_v);
        exp_t x;
        if (kind == 0) begin
            m_cur = cur;
            m_ocd = ocd_v;
        end else if (kind == 1) begin
            m_st = int'(f);
        end else begin
            m_err = (m_err >= 255) ? 255 : m_err + 1;
        end
        x.kind = kind; x.cur = m_cur; x.ocd = m_ocd; x.st = m_st; x.errc = m_err;
        sb.push_back(x);
    endtask

    task automatic wait_cs_fall();
        int n = 0;
        while (CS !== 1'b0 && n < TMO) begin
            @(negedge CLK);
            n++;
        end
        if (n >= TMO) chk("cs_fall_timeout", 0, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (busy !== 1'b0 && n < TMO) begin
            @(negedge CLK);
            n++;
        end
        if (n >= TMO) chk("busy_timeout", 0, 1);
    endtask

    task automatic run_frame(input logic [15:0] f, input int kind, input int cur, input int ocd_v);
        next_frame = f;
        push_exp(kind, f, cur, ocd_v);
        wait_cs_fall();
        wait_done();
    endtask

    // Monitor: SCK shape per frame, CS/SCK idle relation, and scoreboard pops on result pulses.
    initial begin : monitor
        forever begin
            @(negedge CLK);
            if (!reset_n) begin
                prev_cs = 1; prev_sck = 0; in_frame = 0; sck_edges = 0; hi_len = 0;
            end else begin
                if (CS === 1'b1 && CS_CLK === 1'b1) bad_idle++;
                if (prev_cs == 1 && CS === 1'b0) begin
                    in_frame = 1; sck_edges = 0; cs_fall_cyc = cyc; cs_falls++;
                end
                if (CS_CLK === 1'b1 && prev_sck == 0) begin
                    sck_edges++; hi_len = 1;
                end else if (CS_CLK === 1'b1) begin
                    hi_len++;
                end else if (prev_sck == 1) begin
                    chk("sck_high_len", hi_len, DIV);
                end
                if (prev_cs == 0 && CS === 1'b1 && in_frame == 1) begin
                    chk("sck_edges", sck_edges, 16);
                    in_frame = 0;
                end
                npulse = int'(current_valid) + int'(status_valid) + int'(parity_err);
                if (npulse != 0) begin
                    chk("pulse_onehot", npulse, 1);
                    if (sb.size() == 0) begin
                        chk("unexpected_pulse", npulse, 0);
                    end else begin
                        e = sb.pop_front();
                        kind_act = parity_err ? 2 : (status_valid ? 1 : 0);
                        cur_act  = current;
                        chk("kind", kind_act, e.kind);
                        chk("current", cur_act, e.cur);
                        chk("ocd", int'(ocd), e.ocd);
                        chk("status", int'(status), e.st);
                        chk("err_count", int'(err_count), e.errc);
                        chk("latency", cyc - cs_fall_cyc, LAT);
                    end
                end
                prev_cs  = (CS === 1'b1) ? 1 : 0;
                prev_sck = (CS_CLK === 1'b1) ? 1 : 0;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int falls_before;
        int en_cyc;
        int exp_fall;
        int n;

        // Hand-computed vectors: frame, kind, current, ocd.
        vecs[0] = '{16'h5000, 0, 0,    0};
        vecs[1] = '{16'h1800, 0, 2048, 0};
        vecs[2] = '{16'h3000, 0, 0,    1};
        vecs[3] = '{16'h0FFF, 0, -1,   0};
        vecs[4] = '{16'h0001, 2, 0,    0};
        vecs[5] = '{16'h8001, 1, 0,    0};
        vecs[6] = '{16'h8003, 2, 0,    0};

        reset_n = 1'b0;
        enable  = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_cs", int'(CS), 1);
        chk("rst_cs_clk", int'(CS_CLK), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_current", int'(current), 0);
        chk("rst_status", int'(status), 0);
        chk("rst_err_count", int'(err_count), 0);
        chk("rst_pulses", int'(current_valid) + int'(status_valid) + int'(parity_err), 0);

        // First frame: CS must fall at cycle SP after release.
        next_frame = vecs[0].f;
        push_exp(vecs[0].kind, vecs[0].f, vecs[0].cur, vecs[0].ocd);
        reset_n = 1'b1;
        wait_cs_fall();
        chk("first_cs_fall_cyc", cyc, SP);
        wait_done();

        for (int i = 1; i < 7; i++) begin
            run_frame(vecs[i].f, vecs[i].kind, vecs[i].cur, vecs[i].ocd);
        end

        // Run of bad-parity frames pushes err_count into saturation.
        for (int i = 0; i < 300; i++) begin
            run_frame(16'h0001 << (i % 16), 2, 0, 0);
        end
        @(negedge CLK);
        chk("err_saturated", int'(err_count), 255);
        chk("status_held", int'(status), 16'h8001);

        // Reset in the middle of the shift phase.
        next_frame = 16'h1800;
        wait_cs_fall();
        n = 0;
        while (sck_edges < 7 && n < TMO) begin
            @(negedge CLK);
            n++;
        end
        if (n >= TMO) chk("sck7_timeout", 0, 1);
        #3 reset_n = 1'b0;
        #1;
        chk("mid_rst_cs", int'(CS), 1);
        chk("mid_rst_cs_clk", int'(CS_CLK), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_current", int'(current), 0);
        chk("mid_rst_status", int'(status), 0);
        chk("mid_rst_err_count", int'(err_count), 0);
        sb.delete();
        m_cur = 0; m_ocd = 0; m_st = 0; m_err = 0;
        repeat (3) @(negedge CLK);
        next_frame = 16'h1800;
        push_exp(0, 16'h1800, 2048, 0);
        reset_n = 1'b1;
        wait_cs_fall();
        chk("post_rst_cs_fall_cyc", cyc, SP);
        wait_done();

        // Drop enable during SETUP: this frame completes, then silence.
        next_frame = 16'h3000;
        push_exp(0, 16'h3000, 0, 1);
        wait_cs_fall();
        @(negedge CLK);
        enable = 1'b0;
        wait_done();
        falls_before = cs_falls;
        repeat (3 * SP) @(negedge CLK);
        chk("no_cs_while_disabled", cs_falls, falls_before);
        repeat (37) @(negedge CLK);
        enable   = 1'b1;
        en_cyc   = cyc;
        exp_fall = (en_cyc / SP + 1) * SP;
        next_frame = 16'h0FFF;
        push_exp(0, 16'h0FFF, -1, 0);
        wait_cs_fall();
        chk("reenable_cs_fall_cyc", cyc, exp_fall);
        wait_done();

        repeat (5) @(negedge CLK);
        chk("scoreboard_empty", sb.size(), 0);
        chk("sck_high_while_cs_high", bad_idle, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
